divisor_secuencial: RTL



---
 rtl/divisor_secuencial.sv | 134 +++++++++++++
 1 files changed

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider: one quotient bit per cycle through a
// shared (N+1)-bit trial subtractor, driven by a start/done handshake.

module restadorNbits #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         neg
);
    assign {neg, diff} = {1'b0, a} - {1'b0, b};
endmodule

// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// ITER  | one restoring step per edge, N edges in total
// DONE  | result registers just updated; done pulses for one cycle
module divisor_secuencial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         divByZero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic [N:0]    p;
    logic [N:0]    diff;
    logic          neg;
    logic          take;
    logic          last;
    logic [N-1:0]  r_nxt;
    logic [N-1:0]  q_nxt;

    assign p = {r, q[N-1]};

    restadorNbits #(.W(N + 1)) u_sub (
        .a    (p),
        .b    ({1'b0, d}),
        .diff (diff),
        .neg  (neg)
    );

    // Since R < D always holds, diff[N] is zero whenever there is no borrow.
    assign take  = ~(neg | diff[N]);
    assign r_nxt = take ? diff[N-1:0] : p[N-1:0];
    assign q_nxt = {q[N-2:0], take};
    assign last  = (cnt == CW'(N - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            divByZero <= 1'b1;
                        end else begin
                            r   <= '0;
                            q   <= dividend;
                            d   <= divisor;
                            cnt <= '0;
                        end
                    end
                end
                ITER: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        divByZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
